// File: rtl/regfile_np.sv
// regfile_np: NRD-read / 1-write GPR file with EX/WB bypass, debug port and
// post-reset clear sequencer; busy scoreboard built under REGFILE_SCOREBOARD_EN.
module regfile_np #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  ready,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   input  logic                  fwd_valid,
   input  logic [ADDR_W-1:0]     fwd_addr,
   input  logic [DATA_W-1:0]     fwd_data,
   input  logic                  wb_we,
   input  logic [ADDR_W-1:0]     wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [ADDR_W-1:0]     dbg_addr,
   input  logic [DATA_W-1:0]     dbg_wdata,
   output logic                  dbg_ack,
   output logic [DATA_W-1:0]     dbg_rdata,
   input  logic                  sb_set,
   input  logic [ADDR_W-1:0]     sb_addr,
   output logic [NRD-1:0]        rd_busy
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {CLEAR, RUN} state_t;
   typedef enum logic {D_IDLE, D_ACK} dstate_t;

   state_t            state;
   dstate_t           dstate;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] regs [DEPTH];

   logic              run;
   logic              wb_wr;
   logic              dbg_acc;
   logic              dbg_wr;
   logic [DATA_W-1:0] dbg_rd_val;
   logic [ADDR_W-1:0] ra;

   assign run     = (state == RUN);
   assign wb_wr   = run && wb_we && (wb_addr != '0);
   assign dbg_acc = run && (dstate == D_IDLE) && dbg_req &&
                    !(dbg_we && wb_we);
   assign dbg_wr  = dbg_acc && dbg_we && (dbg_addr != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= ADDR_W'(1);
         ready <= 1'b0;
      end else if (state == CLEAR) begin
         cnt <= cnt + ADDR_W'(1);
         if (cnt == '1) begin
            state <= RUN;
            ready <= 1'b1;
         end
      end
   end

   // Storage has no reset so it maps to plain RAM; the sequencer zeroes it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (!run)
            regs[cnt] <= '0;
         else if (wb_wr)
            regs[wb_addr] <= wb_data;
         else if (dbg_wr)
            regs[dbg_addr] <= dbg_wdata;
      end
   end

   always_comb begin
      dbg_rd_val = regs[dbg_addr];
      if (dbg_addr == '0)
         dbg_rd_val = '0;
      else if (wb_we && (wb_addr == dbg_addr))
         dbg_rd_val = wb_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dstate    <= D_IDLE;
         dbg_ack   <= 1'b0;
         dbg_rdata <= '0;
      end else begin
         unique case (dstate)
            D_IDLE: begin
               if (dbg_acc) begin
                  dstate  <= D_ACK;
                  dbg_ack <= 1'b1;
                  if (!dbg_we)
                     dbg_rdata <= dbg_rd_val;
               end
            end
            D_ACK: begin
               dstate  <= D_IDLE;
               dbg_ack <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      rd_data = '0;
      ra      = '0;
      for (int i = 0; i < NRD; i++) begin
         ra = rd_addr[i*ADDR_W +: ADDR_W];
         if (!run || ra == '0)
            rd_data[i*DATA_W +: DATA_W] = '0;
         else if (fwd_valid && fwd_addr == ra)
            rd_data[i*DATA_W +: DATA_W] = fwd_data;
         else if (wb_we && wb_addr == ra)
            rd_data[i*DATA_W +: DATA_W] = wb_data;
         else
            rd_data[i*DATA_W +: DATA_W] = regs[ra];
      end
   end

`ifdef REGFILE_SCOREBOARD_EN
   logic [DEPTH-1:0]  busy;
   logic [ADDR_W-1:0] ba;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else if (run) begin
         if (wb_we)
            busy[wb_addr] <= 1'b0;
         if (sb_set && sb_addr != '0)
            busy[sb_addr] <= 1'b1;
      end
   end

   always_comb begin
      rd_busy = '0;
      ba      = '0;
      for (int i = 0; i < NRD; i++) begin
         ba = rd_addr[i*ADDR_W +: ADDR_W];
         rd_busy[i] = run && busy[ba] &&
                      !(fwd_valid && fwd_addr == ba) &&
                      !(wb_we && wb_addr == ba);
      end
   end
`else
   logic sb_unused;

   assign sb_unused = sb_set ^ (^sb_addr);
   assign rd_busy   = '0;
`endif

endmodule

// File: tb/tb_regfile_np.sv
// tb_regfile_np: directed bench for regfile_np; expected values go through a
// tag/value queue and are popped at each sample point.
module tb_regfile_np;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             ready;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic             fwd_valid;
   logic [AW-1:0]    fwd_addr;
   logic [DW-1:0]    fwd_data;
   logic             wb_we;
   logic [AW-1:0]    wb_addr;
   logic [DW-1:0]    wb_data;
   logic             dbg_req;
   logic             dbg_we;
   logic [AW-1:0]    dbg_addr;
   logic [DW-1:0]    dbg_wdata;
   logic             dbg_ack;
   logic [DW-1:0]    dbg_rdata;
   logic             sb_set;
   logic [AW-1:0]    sb_addr;
   logic [NR-1:0]    rd_busy;

   int tests = 0;
   int fails = 0;
   int n;

   string       tag_q [$];
   logic [63:0] exp_q [$];

   regfile_np #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
      .clk(clk), .rst(rst), .ready(ready),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .sb_set(sb_set), .sb_addr(sb_addr), .rd_busy(rd_busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input string t, input logic [63:0] v);
      tag_q.push_back(t);
      exp_q.push_back(v);
   endtask

   task automatic check(input logic [63:0] obs);
      string       t;
      logic [63:0] e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $error("FAIL sb_empty: got %h required nothing queued", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         assert (obs === e) else begin
            fails++;
            $error("FAIL %s: got %h required %h", t, obs, e);
         end
      end
   endtask

   task automatic set_rd(input int a0, input int a1);
      rd_addr = {AW'(a1), AW'(a0)};
   endtask

   // Runs one clear sequence from the cycle after reset release.
   task automatic clear_phase();
      set_rd(1, 31);
      fwd_valid = 1'b1;
      fwd_addr  = 5'd1;
      fwd_data  = 32'hFFFF_FFFF;
      dbg_req   = 1'b1;
      dbg_we    = 1'b1;
      dbg_addr  = 5'd2;
      dbg_wdata = 32'h0BAD_0BAD;
      n = 0;
      while (!ready && n < 40) begin
         push_exp("clear_rd_zero", 64'h0);
         check(rd_data);
         push_exp("clear_no_ack", 64'h0);
         check({63'h0, dbg_ack});
         tick();
         n++;
      end
      fwd_valid = 1'b0;
      dbg_req   = 1'b0;
      push_exp("ready_edge", 64'd31);
      check(64'(n));
   endtask

   task automatic read_all_zero();
      for (int a = 0; a < 32; a += 2) begin
         set_rd(a, a + 1);
         #1;
         push_exp("post_clear_zero", 64'h0);
         check(rd_data);
      end
   endtask

   initial begin
      rst       = 1'b1;
      rd_addr   = '0;
      fwd_valid = 1'b0;
      fwd_addr  = '0;
      fwd_data  = '0;
      wb_we     = 1'b0;
      wb_addr   = '0;
      wb_data   = '0;
      dbg_req   = 1'b0;
      dbg_we    = 1'b0;
      dbg_addr  = '0;
      dbg_wdata = '0;
      sb_set    = 1'b0;
      sb_addr   = '0;
      #1;
      push_exp("rst_ready", 64'h0);      check({63'h0, ready});
      push_exp("rst_ack", 64'h0);        check({63'h0, dbg_ack});
      push_exp("rst_rdata", 64'h0);      check({32'h0, dbg_rdata});
      push_exp("rst_busy", 64'h0);       check({62'h0, rd_busy});
      push_exp("rst_rd", 64'h0);         check(rd_data);

      tick();
      tick();
      rst = 1'b0;
      clear_phase();
      read_all_zero();

      wb_we   = 1'b1;
      wb_addr = 5'd5;
      wb_data = 32'hDEAD_BEEF;
      set_rd(5, 0);
      #1;
      push_exp("x5_bypass", 64'h0000_0000_DEAD_BEEF);
      check(rd_data);
      tick();
      wb_we = 1'b0;
      #1;
      push_exp("x5_array", 64'h0000_0000_DEAD_BEEF);
      check(rd_data);

      wb_we   = 1'b1;
      wb_addr = 5'd0;
      wb_data = 32'h1;
      set_rd(0, 0);
      #1;
      push_exp("x0_bypass", 64'h0);
      check(rd_data);
      tick();
      wb_we = 1'b0;
      #1;
      push_exp("x0_array", 64'h0);
      check(rd_data);

      fwd_valid = 1'b1;
      fwd_addr  = 5'd7;
      fwd_data  = 32'h11;
      wb_we     = 1'b1;
      wb_addr   = 5'd7;
      wb_data   = 32'h22;
      set_rd(7, 7);
      #1;
      push_exp("fwd_over_wb", 64'h0000_0011_0000_0011);
      check(rd_data);
      tick();
      fwd_valid = 1'b0;
      wb_we     = 1'b0;
      #1;
      push_exp("x7_array", 64'h0000_0022_0000_0022);
      check(rd_data);

      set_rd(3, 10);
      dbg_req   = 1'b1;
      dbg_we    = 1'b1;
      dbg_addr  = 5'd3;
      dbg_wdata = 32'hA5A5_A5A5;
      wb_we     = 1'b1;
      wb_addr   = 5'd10;
      wb_data   = 32'h0000_1010;
      n = 0;
      while (!dbg_ack && n < 10) begin
         tick();
         n++;
         if (n == 2)
            wb_we = 1'b0;
      end
      dbg_req = 1'b0;
      push_exp("dbg_wr_latency", 64'd3);
      check(64'(n));
      #1;
      push_exp("dbg_wr_array", 64'h0000_1010_A5A5_A5A5);
      check(rd_data);
      tick();
      push_exp("dbg_ack_pulse", 64'h0);
      check({63'h0, dbg_ack});

      dbg_req  = 1'b1;
      dbg_we   = 1'b0;
      dbg_addr = 5'd3;
      n = 0;
      while (!dbg_ack && n < 10) begin
         tick();
         n++;
      end
      dbg_req = 1'b0;
      push_exp("dbg_rd_latency", 64'd1);
      check(64'(n));
      push_exp("dbg_rd_data", 64'hA5A5_A5A5);
      check({32'h0, dbg_rdata});
      tick();
      push_exp("dbg_rd_ack_low", 64'h0);
      check({63'h0, dbg_ack});
      push_exp("dbg_rd_held", 64'hA5A5_A5A5);
      check({32'h0, dbg_rdata});

      dbg_req  = 1'b1;
      dbg_addr = 5'd12;
      wb_we    = 1'b1;
      wb_addr  = 5'd12;
      wb_data  = 32'h0000_1234;
      tick();
      dbg_req = 1'b0;
      wb_we   = 1'b0;
      push_exp("dbg_rd_wb_ack", 64'h1);
      check({63'h0, dbg_ack});
      push_exp("dbg_rd_wb_bypass", 64'h1234);
      check({32'h0, dbg_rdata});
      tick();

`ifdef REGFILE_SCOREBOARD_EN
      set_rd(9, 0);
      sb_set  = 1'b1;
      sb_addr = 5'd9;
      #1;
      push_exp("sb_not_yet", 64'h0);
      check({62'h0, rd_busy});
      tick();
      sb_set = 1'b0;
      #1;
      push_exp("sb_busy", 64'h1);
      check({62'h0, rd_busy});
      fwd_valid = 1'b1;
      fwd_addr  = 5'd9;
      #1;
      push_exp("sb_fwd_mask", 64'h0);
      check({62'h0, rd_busy});
      fwd_valid = 1'b0;
      wb_we     = 1'b1;
      wb_addr   = 5'd9;
      wb_data   = 32'h99;
      #1;
      push_exp("sb_wb_mask", 64'h0);
      check({62'h0, rd_busy});
      tick();
      wb_we = 1'b0;
      #1;
      push_exp("sb_cleared", 64'h0);
      check({62'h0, rd_busy});
      sb_set  = 1'b1;
      sb_addr = 5'd9;
      wb_we   = 1'b1;
      tick();
      sb_set = 1'b0;
      wb_we  = 1'b0;
      #1;
      push_exp("sb_set_wins", 64'h1);
      check({62'h0, rd_busy});
      sb_set  = 1'b1;
      sb_addr = 5'd0;
      tick();
      sb_set = 1'b0;
      #1;
      push_exp("sb_x0_never", 64'h1);
      check({62'h0, rd_busy});
`else
      set_rd(9, 0);
      sb_set  = 1'b1;
      sb_addr = 5'd9;
      tick();
      sb_set = 1'b0;
      #1;
      push_exp("sb_absent", 64'h0);
      check({62'h0, rd_busy});
`endif

      for (int i = 1; i < 32; i++) begin
         wb_we   = 1'b1;
         wb_addr = AW'(i);
         wb_data = 32'hC0DE_0000 | 32'(i);
         tick();
      end
      wb_we = 1'b0;
      set_rd(1, 31);
      #1;
      push_exp("garbage_fill", 64'hC0DE_001F_C0DE_0001);
      check(rd_data);

      dbg_req  = 1'b1;
      dbg_we   = 1'b0;
      dbg_addr = 5'd5;
      tick();
      push_exp("pre_rst_ack", 64'h1);
      check({63'h0, dbg_ack});
      #2;
      rst     = 1'b1;
      dbg_req = 1'b0;
      #1;
      push_exp("mid_rst_ack", 64'h0);
      check({63'h0, dbg_ack});
      push_exp("mid_rst_ready", 64'h0);
      check({63'h0, ready});
      push_exp("mid_rst_rdata", 64'h0);
      check({32'h0, dbg_rdata});
      push_exp("mid_rst_busy", 64'h0);
      check({62'h0, rd_busy});
      tick();
      rst = 1'b0;
      clear_phase();
      read_all_zero();
      set_rd(9, 9);
      #1;
      push_exp("busy_after_rst", 64'h0);
      check({62'h0, rd_busy});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/regfile_np.md
# regfile_np

Parametrised general-purpose register file for the core's decode stage: N combinational read ports, one synchronous write-back port, address-compared EX forwarding, and a debug (JTAG) port with a req/ack handshake. After reset, a clear sequencer zeroes the array one entry per cycle, so the storage array needs no reset and maps to plain RAM. An optional scoreboard tracks in-flight destination registers for the hazard unit.

## Interface
- `DATA_W`, 32, register width.
- `ADDR_W`, 5, address width; depth = 2^ADDR_W; entry 0 is hardwired zero.
- `NRD`, 2, number of read ports.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; one clock, reset asynchronous and active-high.
- `ready`  out  1  high when the clear sequence is done and the array is usable.
- `rd_addr`  in  NRD*ADDR_W  read addresses; port i is at bits [i*ADDR_W +: ADDR_W].
- `rd_data`  out  NRD*DATA_W  read data, combinational.
- `fwd_valid`  in  1  EX result valid this cycle.
- `fwd_addr`  in  ADDR_W  EX destination register.
- `fwd_data`  in  DATA_W  EX result.
- `wb_we`  in  1  write-back enable.
- `wb_addr`  in  ADDR_W  write-back address.
- `wb_data`  in  DATA_W  write-back data.
- `dbg_req`  in  1  debug request; held until `dbg_ack`.
- `dbg_we`  in  1  1 = write, 0 = read; stable while `dbg_req` is high.
- `dbg_addr`  in  ADDR_W  debug address.
- `dbg_wdata`  in  DATA_W  debug write data.
- `dbg_ack`  out  1  single-cycle completion pulse.
- `dbg_rdata`  out  DATA_W  debug read data; valid when `dbg_ack` is high, and held afterwards.
- `sb_set`  in  1  mark `sb_addr` busy (instruction issued). Scoreboard build only.
- `sb_addr`  in  ADDR_W  address to mark busy.
- `rd_busy`  out  NRD  per-read-port busy flag.

## Operation
- Main FSM states: CLEAR and RUN.
- CLEAR:
  - Entered on reset. The clear counter starts at 1.
  - Each cycle, write 0 to `regs[cnt]` and increment `cnt`.
  - After writing entry 2^ADDR_W-1, move to RUN.
  - `wb_we`, `sb_set` and `dbg_req` are ignored while in CLEAR.
  - `rd_data` is forced to 0 while in CLEAR.
- RUN: `ready` = 1.
- Read mux per port, highest priority first:
  1. Address 0 returns 0.
  2. If `fwd_valid` and `fwd_addr` equals the read address, return `fwd_data`.
  3. If `wb_we` and `wb_addr` equals the read address, return `wb_data`.
  4. Otherwise return the array contents.
- Write port: at the clock edge, when `wb_we` is high and `wb_addr` is non-zero, `regs[wb_addr]` ← `wb_data`. Writes to address 0 are dropped.
- Debug FSM: D_IDLE and D_ACK.
  - D_IDLE: with `dbg_req` high in RUN, the request is accepted at the edge, except for a debug write in a cycle where `wb_we` is high. That write is deferred, because write-back always wins.
  - On acceptance: a debug write updates the array (address 0 is dropped); a debug read latches `regs[dbg_addr]` into `dbg_rdata`, including a bypass of a same-cycle `wb_we` to the same address. The FSM then goes to D_ACK.
  - D_ACK: `dbg_ack` = 1 for one cycle, then return to D_IDLE. No new request is accepted in D_ACK.
- Reset mid-operation: all state returns to its reset value, and CLEAR restarts from entry 1. An in-flight debug request is dropped and is never acknowledged.

## Timing
- Reset values:
  - `ready` = 0, `dbg_ack` = 0, `dbg_rdata` = 0.
  - `rd_busy` = 0, with all busy bits cleared.
  - FSMs in CLEAR / D_IDLE.
- `ready` rises on the 2^ADDR_W-1 th rising edge after `rst` deasserts (31 edges for the defaults).
- Read latency is 0 cycles (combinational). A write is visible in the array on the cycle after its edge, and through the bypass in the same cycle.
- Debug latency, from `dbg_req` high to `dbg_ack`:
  - Minimum 1 edge: accepted at edge N, `dbg_ack` high during cycle N+1.
  - Each cycle of write-back conflict adds one cycle.
- Back-to-back debug requests complete at most one per 2 cycles.

## Configuration
- `REGFILE_SCOREBOARD_EN` defined:
  - One busy bit per entry.
  - `sb_set` sets `busy[sb_addr]` at the edge. A `wb_we` write clears `busy[wb_addr]`.
  - When set and clear hit the same address in the same cycle, set wins.
  - Address 0 is never busy.
  - `rd_busy[i]` = `busy[rd_addr_i]`, masked to 0 when the fwd or wb bypass hits for that port.
  - All busy bits are cleared by reset and stay 0 during CLEAR.
- Not defined: `rd_busy` is tied to 0, `sb_set` and `sb_addr` are ignored, and no busy storage is built.

## Test plan
- Release reset with the array pre-filled with garbage by backdoor:
  - `ready` rises at edge 31.
  - All 32 reads then return 0.
  - `rd_data` is 0 throughout CLEAR.
- RUN, write x5 = 0xDEADBEEF, port 0 reading x5:
  - Port 0 returns 0xDEADBEEF in the same cycle through the bypass, and from the array afterwards.
  - `wb_addr`=0 with data 0x1 leaves x0 reading 0.
- In the same cycle, `fwd_valid` with x7 = 0x11 and `wb_we` with x7 = 0x22, ports 0 and 1 both reading x7 → both return 0x11.
- Debug write x3 = 0xA5A5A5A5 issued while `wb_we` is high for 2 cycles, then a debug read of x3:
  - The write's `dbg_ack` comes 3 cycles after request.
  - The read returns 0xA5A5A5A5 one cycle after request.
- With `REGFILE_SCOREBOARD_EN`:
  - `sb_set` x9 → `rd_busy[0]` = 1 on the next cycle while port 0 reads x9.
  - A cycle with `wb_we` x9 → `rd_busy[0]` = 0 in that cycle through the mask, with the bit cleared afterwards.
  - A cycle with `sb_set` and `wb_we` both on x9 → x9 stays busy.
- Assert `rst` while a debug read is pending in D_ACK → `dbg_ack` = 0 immediately, CLEAR restarts, and `ready` = 0 for 31 edges.
